// File: rtl/aes_pkg.sv
// Shared AES inverse-cipher control definitions: FSM state encoding, round
// count defaults and the registered control-flag payload.
package aes_pkg;

   localparam int unsigned NR_DEF = 10;  // AES-128 round count
   localparam int unsigned RW_DEF = 4;   // round index width, 2**RW_DEF > NR_DEF

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_INIT  = 3'd1,
      ST_ROUND = 3'd2,
      ST_FINAL = 3'd3,
      ST_HOLD  = 3'd4
   } state_e;

   // Control outputs, all taken straight from flops.
   typedef struct packed {
      logic in_ready;
      logic load_state;
      logic last_round;
      logic busy;
      logic out_valid;
   } ctrl_flags_t;

   // Flag values the controller presents while sitting in state st.
   function automatic ctrl_flags_t flags_for(input state_e st, input logic key_ready);
      ctrl_flags_t f;
      f = '0;
      case (st)
         ST_IDLE:  f.in_ready   = key_ready;
         ST_INIT:  begin
            f.load_state = 1'b1;
            f.busy       = 1'b1;
         end
         ST_ROUND: f.busy       = 1'b1;
         ST_FINAL: begin
            f.last_round = 1'b1;
            f.busy       = 1'b1;
         end
         ST_HOLD:  f.out_valid  = 1'b1;
         default:  f = '0;
      endcase
      return f;
   endfunction

endpackage

// File: rtl/inv_round_ctrl_if.sv
// Handshake and datapath-control bundle between the inverse-cipher round
// controller (slave) and its environment (master).
//   In_Valid/In_Ready   : ciphertext input handshake
//   Key_Ready           : key schedule stored and stable
//   Clear               : synchronous abort
//   Round_Num           : round-key index
//   Load_State/Last_Round/Busy : datapath control and status
//   Out_Valid/Out_Ready : plaintext output handshake
interface inv_round_ctrl_if #(
   parameter int unsigned RW = aes_pkg::RW_DEF
) ();

   logic          In_Valid;
   logic          In_Ready;
   logic          Key_Ready;
   logic          Clear;
   logic [RW-1:0] Round_Num;
   logic          Load_State;
   logic          Last_Round;
   logic          Busy;
   logic          Out_Valid;
   logic          Out_Ready;

   modport master (
      output In_Valid, Key_Ready, Clear, Out_Ready,
      input  In_Ready, Round_Num, Load_State, Last_Round, Busy, Out_Valid
   );

   modport slave (
      input  In_Valid, Key_Ready, Clear, Out_Ready,
      output In_Ready, Round_Num, Load_State, Last_Round, Busy, Out_Valid
   );

endinterface

// File: rtl/round_down_cnt.sv
// Round index counter: presets to NR, loads NR-1, decrements saturating at 0.
//   clk, rst_n : clock, async active-low reset (count resets to NR)
//   preset_i   : load NR (highest priority)
//   load_i     : load NR-1
//   dec_i      : decrement, holding at 0
//   cnt_o      : current round index
//   last_o     : count is at 1 or below, i.e. the next decrement reaches zero
module round_down_cnt
   import aes_pkg::*;
#(
   parameter int unsigned NR = NR_DEF,
   parameter int unsigned RW = RW_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          preset_i,
   input  logic          load_i,
   input  logic          dec_i,
   output logic [RW-1:0] cnt_o,
   output logic          last_o
);

   localparam logic [RW-1:0] CNT_NR   = RW'(NR);
   localparam logic [RW-1:0] CNT_LOAD = RW'(NR - 1);
   localparam logic [RW-1:0] CNT_ONE  = RW'(1);

   logic [RW-1:0] cnt_q;
   logic [RW-1:0] cnt_d;

   // Next count; never wraps below zero, never rises above NR.
   always_comb begin
      cnt_d = cnt_q;
      if (preset_i) begin
         cnt_d = CNT_NR;
      end else if (load_i) begin
         cnt_d = CNT_LOAD;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - CNT_ONE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= CNT_NR;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o  = cnt_q;
   assign last_o = (cnt_q <= CNT_ONE);

endmodule

// File: rtl/inv_round_ctrl.sv
// AES inverse-cipher round controller. Accepts one ciphertext block, loads
// it with key[NR], steps the round index NR-1..1, runs the final round at 0
// without InvMixColumns and holds the plaintext until it is taken.
//   CLK, nRST : clock, asynchronous active-low reset
//   bus       : handshake / datapath control bundle (slave side)
module inv_round_ctrl
   import aes_pkg::*;
#(
   parameter int unsigned NR = NR_DEF,
   parameter int unsigned RW = RW_DEF
) (
   input  logic             CLK,
   input  logic             nRST,
   inv_round_ctrl_if.slave  bus
);

   state_e        state_q;
   state_e        state_d;
   ctrl_flags_t   flags_q;
   ctrl_flags_t   flags_d;

   logic          cnt_preset;
   logic          cnt_load;
   logic          cnt_dec;
   logic [RW-1:0] cnt;
   logic          cnt_last;

   round_down_cnt #(
      .NR (NR),
      .RW (RW)
   ) u_round_cnt (
      .clk      (CLK),
      .rst_n    (nRST),
      .preset_i (cnt_preset),
      .load_i   (cnt_load),
      .dec_i    (cnt_dec),
      .cnt_o    (cnt),
      .last_o   (cnt_last)
   );

   // Next state, counter control and next registered flags.
   always_comb begin
      state_d    = state_q;
      cnt_preset = 1'b0;
      cnt_load   = 1'b0;
      cnt_dec    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // In_Ready already folds in Key_Ready, so the key is only sampled here.
            if (bus.In_Valid && flags_q.in_ready) begin
               state_d = ST_INIT;
            end
         end
         ST_INIT: begin
            state_d  = ST_ROUND;
            cnt_load = 1'b1;
         end
         ST_ROUND: begin
            cnt_dec = 1'b1;
            if (cnt_last) begin
               state_d = ST_FINAL;
            end
         end
         ST_FINAL: begin
            state_d = ST_HOLD;
         end
         ST_HOLD: begin
            if (bus.Out_Ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Abort wins over every handshake.
      if (bus.Clear) begin
         state_d = ST_IDLE;
      end

      // Any entry to IDLE (done, abort, bad encoding) re-arms the index at NR.
      if (state_d == ST_IDLE) begin
         cnt_preset = 1'b1;
      end

      flags_d = flags_for(state_d, bus.Key_Ready);
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q <= ST_IDLE;
         flags_q <= '0;
      end else begin
         state_q <= state_d;
         flags_q <= flags_d;
      end
   end

   assign bus.In_Ready   = flags_q.in_ready;
   assign bus.Load_State = flags_q.load_state;
   assign bus.Last_Round = flags_q.last_round;
   assign bus.Busy       = flags_q.busy;
   assign bus.Out_Valid  = flags_q.out_valid;
   assign bus.Round_Num  = cnt;

endmodule

// File: tb/tb_inv_round_ctrl.sv
// Directed bench for inv_round_ctrl with NR=10, RW=4.
module tb_inv_round_ctrl;

   localparam int unsigned NR = 10;
   localparam int unsigned RW = 4;

   logic clk  = 1'b0;
   logic nrst = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;

   inv_round_ctrl_if #(.RW(RW)) bus ();

   inv_round_ctrl #(.NR(NR), .RW(RW)) dut (
      .CLK  (clk),
      .nRST (nrst),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   // Load_State, Last_Round and Out_Valid never overlap.
   always @(negedge clk) begin
      if (nrst) begin
         n_tests++;
         if ((int'(bus.Load_State) + int'(bus.Last_Round) + int'(bus.Out_Valid)) > 1) begin
            n_fail++;
            $display("FAIL exclusive: load=%0b last=%0b ov=%0b expected at most one set",
                     bus.Load_State, bus.Last_Round, bus.Out_Valid);
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Wait (bounded) for In_Ready, then present one block for one cycle.
   task automatic start_block;
      int waited;
      waited = 0;
      while (bus.In_Ready !== 1'b1 && waited < 20) begin
         tick();
         waited++;
      end
      n_tests++;
      if (bus.In_Ready !== 1'b1) begin
         n_fail++;
         $display("FAIL start_block: In_Ready=%b expected 1 within 20 cycles", bus.In_Ready);
      end
      bus.In_Valid = 1'b1;
      tick();
      bus.In_Valid = 1'b0;
   endtask

   task automatic test_reset;
      #2 nrst = 1'b0;
      #1;
      n_tests++;
      if (bus.Round_Num !== 4'd10) begin
         n_fail++;
         $display("FAIL reset_round: Round_Num=%0d expected 10", bus.Round_Num);
      end
      n_tests++;
      if ({bus.In_Ready, bus.Load_State, bus.Last_Round, bus.Busy, bus.Out_Valid} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_flags: rdy/ld/last/busy/ov=%b expected 00000",
                  {bus.In_Ready, bus.Load_State, bus.Last_Round, bus.Busy, bus.Out_Valid});
      end
      bus.Key_Ready = 1'b1;
      tick();
      nrst = 1'b1;
      tick();
      n_tests++;
      if ({bus.In_Ready, bus.Busy, bus.Round_Num} !== {1'b1, 1'b0, 4'd10}) begin
         n_fail++;
         $display("FAIL reset_release: rdy=%b busy=%b rn=%0d expected 1 0 10",
                  bus.In_Ready, bus.Busy, bus.Round_Num);
      end
   endtask

   task automatic test_single_block;
      logic [3:0] exp_rn;
      n_tests++;
      if (bus.In_Ready !== 1'b1) begin
         n_fail++;
         $display("FAIL single_ready: In_Ready=%b expected 1", bus.In_Ready);
      end
      bus.In_Valid = 1'b1;
      tick();
      bus.In_Valid = 1'b0;
      n_tests++;
      if ({bus.Load_State, bus.Busy, bus.In_Ready, bus.Round_Num} !== {1'b1, 1'b1, 1'b0, 4'd10}) begin
         n_fail++;
         $display("FAIL single_init: ld=%b busy=%b rdy=%b rn=%0d expected 1 1 0 10",
                  bus.Load_State, bus.Busy, bus.In_Ready, bus.Round_Num);
      end
      for (int k = 1; k <= 9; k++) begin
         tick();
         exp_rn = 4'(10 - k);
         n_tests++;
         if ({bus.Round_Num, bus.Load_State, bus.Last_Round, bus.Out_Valid, bus.Busy} !==
             {exp_rn, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL single_round%0d: rn=%0d ld=%b last=%b ov=%b busy=%b expected rn=%0d 0 0 0 1",
                     k, bus.Round_Num, bus.Load_State, bus.Last_Round, bus.Out_Valid, bus.Busy, exp_rn);
         end
      end
      tick();
      n_tests++;
      if ({bus.Round_Num, bus.Last_Round, bus.Busy, bus.Out_Valid} !== {4'd0, 1'b1, 1'b1, 1'b0}) begin
         n_fail++;
         $display("FAIL single_final: rn=%0d last=%b busy=%b ov=%b expected 0 1 1 0",
                  bus.Round_Num, bus.Last_Round, bus.Busy, bus.Out_Valid);
      end
      tick();
      n_tests++;
      if ({bus.Out_Valid, bus.Busy, bus.Last_Round, bus.Round_Num} !== {1'b1, 1'b0, 1'b0, 4'd0}) begin
         n_fail++;
         $display("FAIL single_hold_c11: ov=%b busy=%b last=%b rn=%0d expected 1 0 0 0",
                  bus.Out_Valid, bus.Busy, bus.Last_Round, bus.Round_Num);
      end
      bus.Out_Ready = 1'b1;
      tick();
      bus.Out_Ready = 1'b0;
      n_tests++;
      if ({bus.Out_Valid, bus.In_Ready, bus.Round_Num} !== {1'b0, 1'b1, 4'd10}) begin
         n_fail++;
         $display("FAIL single_done: ov=%b rdy=%b rn=%0d expected 0 1 10",
                  bus.Out_Valid, bus.In_Ready, bus.Round_Num);
      end
   endtask

   task automatic test_key_not_ready;
      bus.Key_Ready = 1'b0;
      tick();
      n_tests++;
      if (bus.In_Ready !== 1'b0) begin
         n_fail++;
         $display("FAIL nokey_ready: In_Ready=%b expected 0", bus.In_Ready);
      end
      bus.In_Valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick();
         n_tests++;
         if ({bus.In_Ready, bus.Busy, bus.Load_State, bus.Round_Num} !== {1'b0, 1'b0, 1'b0, 4'd10}) begin
            n_fail++;
            $display("FAIL nokey_idle%0d: rdy=%b busy=%b ld=%b rn=%0d expected 0 0 0 10",
                     k, bus.In_Ready, bus.Busy, bus.Load_State, bus.Round_Num);
         end
      end
      bus.In_Valid  = 1'b0;
      bus.Key_Ready = 1'b1;
      tick();
      n_tests++;
      if (bus.In_Ready !== 1'b1) begin
         n_fail++;
         $display("FAIL nokey_restore: In_Ready=%b expected 1", bus.In_Ready);
      end
   endtask

   task automatic test_hold_stall;
      start_block();
      repeat (11) tick();
      n_tests++;
      if (bus.Out_Valid !== 1'b1) begin
         n_fail++;
         $display("FAIL stall_enter: Out_Valid=%b expected 1", bus.Out_Valid);
      end
      for (int k = 0; k < 4; k++) begin
         tick();
         n_tests++;
         if ({bus.Out_Valid, bus.Round_Num, bus.Busy} !== {1'b1, 4'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL stall_hold%0d: ov=%b rn=%0d busy=%b expected 1 0 0",
                     k, bus.Out_Valid, bus.Round_Num, bus.Busy);
         end
      end
      bus.Out_Ready = 1'b1;
      tick();
      bus.Out_Ready = 1'b0;
      n_tests++;
      if ({bus.Out_Valid, bus.Round_Num, bus.In_Ready} !== {1'b0, 4'd10, 1'b1}) begin
         n_fail++;
         $display("FAIL stall_release: ov=%b rn=%0d rdy=%b expected 0 10 1",
                  bus.Out_Valid, bus.Round_Num, bus.In_Ready);
      end
   endtask

   task automatic test_clear;
      logic seen_out;
      start_block();
      repeat (5) tick();
      n_tests++;
      if (bus.Round_Num !== 4'd5) begin
         n_fail++;
         $display("FAIL clear_pre: Round_Num=%0d expected 5", bus.Round_Num);
      end
      bus.Clear     = 1'b1;
      bus.In_Valid  = 1'b1;
      bus.Out_Ready = 1'b1;
      tick();
      bus.Clear     = 1'b0;
      bus.In_Valid  = 1'b0;
      bus.Out_Ready = 1'b0;
      n_tests++;
      if ({bus.Round_Num, bus.Busy, bus.Out_Valid, bus.Load_State, bus.Last_Round} !==
          {4'd10, 1'b0, 1'b0, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL clear_abort: rn=%0d busy=%b ov=%b ld=%b last=%b expected 10 0 0 0 0",
                  bus.Round_Num, bus.Busy, bus.Out_Valid, bus.Load_State, bus.Last_Round);
      end
      seen_out = 1'b0;
      for (int k = 0; k < 14; k++) begin
         tick();
         if (bus.Out_Valid !== 1'b0 || bus.Busy !== 1'b0) seen_out = 1'b1;
      end
      n_tests++;
      if (seen_out !== 1'b0) begin
         n_fail++;
         $display("FAIL clear_discard: activity after abort=%b expected 0", seen_out);
      end
      // Clear also beats an accept in IDLE.
      bus.Clear    = 1'b1;
      bus.In_Valid = 1'b1;
      tick();
      bus.Clear    = 1'b0;
      bus.In_Valid = 1'b0;
      n_tests++;
      if ({bus.Load_State, bus.Busy, bus.Round_Num} !== {1'b0, 1'b0, 4'd10}) begin
         n_fail++;
         $display("FAIL clear_idle_prio: ld=%b busy=%b rn=%0d expected 0 0 10",
                  bus.Load_State, bus.Busy, bus.Round_Num);
      end
   endtask

   task automatic test_key_drop;
      start_block();
      bus.Key_Ready = 1'b0;
      repeat (11) tick();
      n_tests++;
      if ({bus.Out_Valid, bus.Round_Num} !== {1'b1, 4'd0}) begin
         n_fail++;
         $display("FAIL keydrop_hold: ov=%b rn=%0d expected 1 0", bus.Out_Valid, bus.Round_Num);
      end
      bus.Out_Ready = 1'b1;
      tick();
      bus.Out_Ready = 1'b0;
      n_tests++;
      if ({bus.Out_Valid, bus.In_Ready} !== {1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL keydrop_idle: ov=%b rdy=%b expected 0 0", bus.Out_Valid, bus.In_Ready);
      end
      bus.Key_Ready = 1'b1;
      tick();
      n_tests++;
      if (bus.In_Ready !== 1'b1) begin
         n_fail++;
         $display("FAIL keydrop_restore: In_Ready=%b expected 1", bus.In_Ready);
      end
   endtask

   task automatic test_async_reset;
      start_block();
      repeat (3) tick();
      n_tests++;
      if (bus.Round_Num !== 4'd7) begin
         n_fail++;
         $display("FAIL arst_pre: Round_Num=%0d expected 7", bus.Round_Num);
      end
      #3 nrst = 1'b0;
      #1;
      n_tests++;
      if ({bus.Round_Num, bus.Busy, bus.In_Ready, bus.Load_State, bus.Last_Round, bus.Out_Valid} !==
          {4'd10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL arst_immediate: rn=%0d busy=%b rdy=%b ld=%b last=%b ov=%b expected 10 0 0 0 0 0",
                  bus.Round_Num, bus.Busy, bus.In_Ready, bus.Load_State, bus.Last_Round, bus.Out_Valid);
      end
      #1 nrst = 1'b1;
      tick();
      n_tests++;
      if ({bus.In_Ready, bus.Busy, bus.Round_Num} !== {1'b1, 1'b0, 4'd10}) begin
         n_fail++;
         $display("FAIL arst_release: rdy=%b busy=%b rn=%0d expected 1 0 10",
                  bus.In_Ready, bus.Busy, bus.Round_Num);
      end
   endtask

   task automatic test_back_to_back;
      int acc[$];
      int ov_cyc;
      int waited;
      ov_cyc = -1;
      bus.In_Valid  = 1'b1;
      bus.Out_Ready = 1'b1;
      for (int c = 0; c < 40; c++) begin
         if (bus.In_Ready === 1'b1) acc.push_back(c);
         tick();
         if (bus.Out_Valid === 1'b1 && ov_cyc < 0) ov_cyc = c;
      end
      bus.In_Valid = 1'b0;
      n_tests++;
      if (acc.size() < 2) begin
         n_fail++;
         $display("FAIL b2b_accepts: accepts=%0d expected at least 2", acc.size());
      end else begin
         n_tests++;
         if (acc[1] - acc[0] !== 13) begin
            n_fail++;
            $display("FAIL b2b_spacing: spacing=%0d expected 13", acc[1] - acc[0]);
         end
         n_tests++;
         if (ov_cyc - acc[0] !== 11) begin
            n_fail++;
            $display("FAIL b2b_latency: latency=%0d expected 11", ov_cyc - acc[0]);
         end
      end
      waited = 0;
      while ((bus.Busy !== 1'b0 || bus.Out_Valid !== 1'b0) && waited < 30) begin
         tick();
         waited++;
      end
      bus.Out_Ready = 1'b0;
      n_tests++;
      if ({bus.Busy, bus.Out_Valid} !== 2'b00) begin
         n_fail++;
         $display("FAIL b2b_drain: busy=%b ov=%b expected 0 0", bus.Busy, bus.Out_Valid);
      end
   endtask

   initial begin
      bus.In_Valid  = 1'b0;
      bus.Key_Ready = 1'b0;
      bus.Clear     = 1'b0;
      bus.Out_Ready = 1'b0;
      test_reset();
      test_single_block();
      test_key_not_ready();
      test_hold_stall();
      test_clear();
      test_key_drop();
      test_async_reset();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
